// File: rtl/srl_fifo_ctrl_if.sv
// ap_fifo handshake bundle between producer/consumer and srl_fifo_ctrl.
// master = producer/consumer side, slave = FIFO controller.
interface srl_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 1
);
  logic                  if_write_ce;
  logic                  if_write;
  logic [DATA_WIDTH-1:0] if_din;
  logic                  if_full_n;
  logic                  if_almost_full_n;
  logic                  if_read_ce;
  logic                  if_read;
  logic [DATA_WIDTH-1:0] if_dout;
  logic                  if_empty_n;

  modport master (
    output if_write_ce, if_write, if_din, if_read_ce, if_read,
    input  if_full_n, if_almost_full_n, if_dout, if_empty_n
  );

  modport slave (
    input  if_write_ce, if_write, if_din, if_read_ce, if_read,
    output if_full_n, if_almost_full_n, if_dout, if_empty_n
  );
endinterface

// File: rtl/srl_fifo_ctrl.sv
// SRL-backed ap_fifo controller: owns the shift-register storage and its occupancy/flags.
// Optional registered output stage under `define SRL_FIFO_CTRL_OREG_EN (capacity DEPTH+1).
module srl_fifo_ctrl #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 1,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = DEPTH - 1
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  srl_fifo_ctrl_if.slave   fif
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);

  logic [CW-1:0]         cnt, cnt_next;
  logic                  full_n_q, afull_n_q;
  logic                  push, pop, srl_dec;
  logic                  srl_we;
  logic [ADDR_WIDTH-1:0] srl_addr;
  logic [DATA_WIDTH-1:0] srl_din, srl_dout;
  logic                  empty_n;

  // SRL storage: newest entry enters at 0, oldest sits at cnt-1; never reset
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge ap_clk) begin
    if (srl_we) begin
      mem[0] <= srl_din;
      for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
    end
  end

  assign srl_dout = mem[srl_addr];
  assign srl_we   = push;
  assign srl_din  = fif.if_din;
  assign srl_addr = (cnt == '0) ? '0 : ADDR_WIDTH'(cnt - CW'(1));

  assign push = fif.if_write & fif.if_write_ce & full_n_q;
  assign pop  = fif.if_read  & fif.if_read_ce  & empty_n;

  always_comb begin
    cnt_next = cnt;
    case ({push, srl_dec})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      cnt       <= '0;
      full_n_q  <= 1'b1;
      afull_n_q <= 1'b1;
    end else begin
      cnt       <= cnt_next;
      full_n_q  <= (cnt_next != DEPTH_C);
      afull_n_q <= (cnt_next < AF_C);
    end
  end

  assign fif.if_full_n        = full_n_q;
  assign fif.if_almost_full_n = afull_n_q;

`ifdef SRL_FIFO_CTRL_OREG_EN
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  load;

  // Refill the output register whenever it is empty or being drained this cycle
  assign load    = (~vld_q | pop) & (cnt != '0);
  assign srl_dec = load;
  assign empty_n = vld_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
    end else if (load) begin
      vld_q  <= 1'b1;
      dout_q <= srl_dout;
    end else if (pop) begin
      vld_q  <= 1'b0;
    end
  end

  assign fif.if_dout    = dout_q;
  assign fif.if_empty_n = vld_q;
`else
  logic empty_n_q;

  assign srl_dec = pop;
  assign empty_n = empty_n_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) empty_n_q <= 1'b0;
    else           empty_n_q <= (cnt_next != '0);
  end

  assign fif.if_dout    = srl_dout;
  assign fif.if_empty_n = empty_n_q;
`endif
endmodule
